regfile_sb: RTL and testbench

Parametrised multi-read-port register file with a per-register pending-write scoreboard for the in-order pipeline. It holds architectural registers, serves combinational reads with same-cycle write-through bypass, and tracks how many in-flight instructions still owe each register a result. Decode consults it for RAW hazards, issue increments a register's pending count, and writeback decrements it.

---
 rtl/regfile_sb_pkg.sv | 17 +
 rtl/regfile_sb_cnt.sv | 43 ++++
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared widths and helpers for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NR_RD_DEF  = 2;
  localparam int unsigned CNT_W_DEF  = 2;

  // Largest number of in-flight writers one register can track.
  localparam int unsigned CNT_MAX = 2 ** CNT_W_DEF - 1;

  // Saturation value for an arbitrary counter width.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// Pending-writer counter for one architectural register.
module regfile_sb_cnt
  import regfile_sb_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             full
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: clear wins, inc+dec cancel, otherwise saturate at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != MaxVal) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);
  assign full = (cnt_q == MaxVal);

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass and a per-register
// pending-write scoreboard used for RAW hazard detection.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NR_RD    = NR_RD_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NR_RD*ADDR_W-1:0] raddr,
  output logic [NR_RD*DATA_W-1:0] rdata,
  output logic [NR_RD-1:0]        rbusy,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_waddr,
  output logic                    iss_ready,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    flush,
  output logic                    err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_d [Depth];
  logic [DATA_W-1:0] mem_q [Depth];
  logic [CNT_W-1:0]  cnt   [Depth];
  logic [Depth-1:0]  busy, full, inc, dec;
  logic              err_d, err_q;
  logic              iss_acc;

  // Register 0 is excluded from both storage and scoreboarding when hardwired.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign iss_ready = is_zero(iss_waddr) || !full[iss_waddr];
  assign iss_acc   = iss_valid && iss_ready && !flush;

  // Decode issue and writeback into per-register count strobes.
  always_comb begin
    inc = '0;
    dec = '0;
    if (iss_acc && !is_zero(iss_waddr)) inc[iss_waddr] = 1'b1;
    if (we && !is_zero(waddr))          dec[waddr]     = 1'b1;
  end

  for (genvar r = 0; r < Depth; r++) begin : g_cnt
    regfile_sb_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[r]),
      .dec (dec[r]),
      .clr (flush),
      .cnt (cnt[r]),
      .busy(busy[r]),
      .full(full[r])
    );
  end

  // Underflow is only an error when no same-cycle issue balances it; flush masks it.
  always_comb begin
    err_d = err_q;
    if (we && !flush && !is_zero(waddr) && !busy[waddr] && !inc[waddr]) err_d = 1'b1;
  end

  // Sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;

  // Array write; writebacks still land during a flush.
  always_comb begin
    mem_d = mem_q;
    if (we && !is_zero(waddr)) mem_d[waddr] = wdata;
  end

  // Data array storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // Read ports: zero register, then same-cycle bypass, then array.
  for (genvar g = 0; g < NR_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;

    assign ra  = raddr[g*ADDR_W +: ADDR_W];
    assign hit = we && (waddr == ra);

    assign rdata[g*DATA_W +: DATA_W] = is_zero(ra) ? '0 :
                                       hit         ? wdata : mem_q[ra];

    // Busy ignores the writer retiring in this very cycle.
    assign rbusy[g] = !is_zero(ra) &&
                      ((cnt[ra] > CNT_W'(1)) || ((cnt[ra] == CNT_W'(1)) && !hit));
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb with a queue-based scoreboard.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_waddr = '0;
  logic        iss_ready;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic        err;

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .iss_valid(iss_valid),
    .iss_waddr(iss_waddr),
    .iss_ready(iss_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .flush    (flush),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        iss_ready;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: architectural values, outstanding-writer counts, error flag.
  logic [31:0] m_mem [32];
  int          m_cnt [32];
  bit          m_err;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  // Busy means writers still outstanding once this cycle's writeback retires.
  function automatic logic m_busy(input logic [4:0] a);
    int left;
    if (a == 0) return 1'b0;
    left = m_cnt[a] - ((we && waddr == a) ? 1 : 0);
    return left > 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endtask

  // One clock cycle: drive inputs, queue the expected response, advance the model.
  task automatic step(input bit rs, input logic [4:0] ra0, input logic [4:0] ra1,
                      input bit iv, input logic [4:0] ia, input bit w,
                      input logic [4:0] wa, input logic [31:0] wd, input bit fl);
    exp_t e;
    bit   rdy;
    int   nc [32];
    @(posedge clk);
    #1;
    rst = rs; raddr = {ra1, ra0}; iss_valid = iv; iss_waddr = ia;
    we = w; waddr = wa; wdata = wd; flush = fl;
    if (rs) m_reset();
    rdy = (ia == 0) || (m_cnt[ia] < 3);
    e.rdata     = {m_read(ra1), m_read(ra0)};
    e.rbusy     = {m_busy(ra1), m_busy(ra0)};
    e.iss_ready = rdy;
    e.err       = m_err;
    exp_q.push_back(e);
    if (!rs) begin
      nc = m_cnt;
      if (fl) begin
        for (int i = 0; i < 32; i++) nc[i] = 0;
      end else begin
        if (iv && rdy && ia != 0) nc[ia] = nc[ia] + 1;
        if (w && wa != 0) begin
          nc[wa] = nc[wa] - 1;
          if (nc[wa] < 0) begin
            nc[wa] = 0;
            m_err  = 1'b1;
          end
        end
      end
      if (w && wa != 0) m_mem[wa] = wd;
      m_cnt = nc;
    end
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    step(0, ra0, ra1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input logic [4:0] a);
    step(0, a, a, 1, a, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (rdata !== e.rdata || rbusy !== e.rbusy || iss_ready !== e.iss_ready ||
          err !== e.err) begin
        n_bad++;
        $display("FAIL outputs @%0t: rdata=%h rbusy=%b ready=%b err=%b, want rdata=%h rbusy=%b ready=%b err=%b",
                 $time, rdata, rbusy, iss_ready, err, e.rdata, e.rbusy, e.iss_ready, e.err);
      end
    end
  end

  initial begin
    m_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Post-reset sweep of every register on both ports.
    for (int a = 0; a < 32; a++) idle(5'(a), 5'(31 - a));

    // Bypass, array readback, hardwired zero.
    step(0, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
    idle(5, 0);
    step(0, 0, 5, 0, 0, 1, 0, 32'h1234, 0);
    idle(0, 5);

    // Two writers on x7 retire one at a time.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(7);
    issue(7);
    step(0, 7, 7, 0, 0, 1, 7, 32'hA5A5_0001, 0);
    step(0, 7, 7, 0, 0, 1, 7, 32'hA5A5_0002, 0);
    idle(7, 7);

    // Saturation on x3: refused issue, retire, balanced issue+retire.
    issue(3);
    issue(3);
    issue(3);
    issue(3);
    step(0, 3, 0, 1, 3, 1, 3, 32'h33, 0);
    step(0, 3, 0, 1, 3, 1, 3, 32'h34, 0);
    issue(3);
    idle(3, 3);

    // Flush beats a simultaneous issue; the writeback still lands.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(9);
    issue(10);
    step(0, 9, 10, 1, 11, 1, 9, 32'h55, 1);
    step(0, 9, 11, 0, 10, 0, 0, 0, 0);
    idle(10, 9);

    // Underflow sets err sticky; async reset clears everything mid-cycle.
    step(0, 12, 9, 0, 0, 1, 12, 32'h12, 0);
    idle(12, 9);
    issue(4);
    idle(4, 12);
    step(1, 12, 4, 0, 4, 0, 0, 0, 0);
    step(0, 12, 4, 0, 4, 0, 0, 0, 0);
    idle(9, 4);

    // Randomized traffic concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ra0, ra1, ia, wa;
      bit         rs, iv, w, fl;
      ra0 = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      ia  = 5'($urandom_range(0, 7));
      wa  = 5'($urandom_range(0, 7));
      iv  = ($urandom_range(0, 99) < 55);
      w   = ($urandom_range(0, 99) < 40);
      fl  = ($urandom_range(0, 99) < 4);
      rs  = ($urandom_range(0, 99) < 2);
      if (w && $urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 8; k++) begin
          logic [4:0] c;
          c = 5'($urandom_range(1, 7));
          if (m_cnt[c] > 0) begin
            wa = c;
            break;
          end
        end
      end
      step(rs, ra0, ra1, iv, ia, w, wa, $urandom, fl);
    end

    idle(0, 0);
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
